// File: rtl/banked_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : banked_ram_pkg
// Description : Shared types and geometry helpers for the banked RAM controller.
// Revision    : 1.0 - initial release
// ============================================================================
package banked_ram_pkg;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int c_perf_w = 16;

    function automatic int num_slices(input int data_w, input int slice_w);
        return data_w / slice_w;
    endfunction

    function automatic int local_addr_w(input int addr_w, input int bank_bits);
        return addr_w - bank_bits;
    endfunction

    function automatic int num_banks(input int bank_bits);
        return 1 << bank_bits;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bank_slice_ram.sv
`default_nettype none
// ============================================================================
// Module      : bank_slice_ram
// Description : Single-port synchronous RAM slice with registered read data.
// Revision    : 1.0 - initial release
// ============================================================================
module bank_slice_ram #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [WIDTH-1:0]  i_wdata,
    output logic [WIDTH-1:0]  o_rdata
);

    logic [WIDTH-1:0] r_mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    // Read register only moves on a read so the response holds between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_rdata <= '0;
        end else if (i_re) begin
            o_rdata <= r_mem[i_addr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/banked_ram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : banked_ram_ctrl
// Description : Banked, slice-masked RAM controller with post-reset zero fill.
//               Optional BANKED_RAM_PERF_EN adds saturating access counters.
// Revision    : 1.0 - initial release
// ============================================================================
module banked_ram_ctrl
    import banked_ram_pkg::*;
#(
    parameter int ADDR_WIDTH  = 12,
    parameter int DATA_WIDTH  = 16,
    parameter int SLICE_WIDTH = 8,
    parameter int BANK_BITS   = 2
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic                                           req_valid,
    output logic                                           req_ready,
    input  logic                                           req_we,
    input  logic [ADDR_WIDTH-1:0]                          req_addr,
    input  logic [DATA_WIDTH-1:0]                          req_wdata,
    input  logic [num_slices(DATA_WIDTH, SLICE_WIDTH)-1:0] req_wmask,
    output logic                                           rsp_valid,
    output logic [DATA_WIDTH-1:0]                          rsp_rdata,
    output logic                                           init_done,
    output logic [c_perf_w-1:0]                            perf_reads,
    output logic [c_perf_w-1:0]                            perf_writes
);

    localparam int c_num_slices = num_slices(DATA_WIDTH, SLICE_WIDTH);
    localparam int c_local_w    = local_addr_w(ADDR_WIDTH, BANK_BITS);
    localparam int c_num_banks  = num_banks(BANK_BITS);

    state_t                 r_state;
    logic [c_local_w-1:0]   r_init_cnt;
    logic                   r_req_ready;
    logic                   r_rsp_valid;
    logic                   r_init_done;
    logic [BANK_BITS-1:0]   r_rd_bank;

    logic                   w_accept;
    logic                   w_wr;
    logic                   w_rd;
    logic                   w_init;
    logic [BANK_BITS-1:0]   w_bank;
    logic [c_local_w-1:0]   w_local;
    logic [c_local_w-1:0]   w_ram_addr;
    logic [c_num_banks-1:0] w_bank_sel;
    logic [c_num_banks-1:0][DATA_WIDTH-1:0] w_bank_rdata;

    assign w_accept   = req_valid & r_req_ready;
    assign w_wr       = w_accept & req_we;
    assign w_rd       = w_accept & ~req_we;
    assign w_init     = (r_state == ST_INIT);
    assign w_bank     = req_addr[ADDR_WIDTH-1 -: BANK_BITS];
    assign w_local    = req_addr[c_local_w-1:0];
    assign w_ram_addr = w_init ? r_init_cnt : w_local;

    always_comb begin
        w_bank_sel         = '0;
        w_bank_sel[w_bank] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_INIT;
            r_init_cnt  <= '0;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_init_done <= 1'b0;
            r_rd_bank   <= '0;
        end else begin
            r_rsp_valid <= w_rd;
            if (w_rd) begin
                r_rd_bank <= w_bank;
            end
            case (r_state)
                ST_INIT: begin
                    r_init_cnt <= r_init_cnt + 1'b1;
                    if (r_init_cnt == '1) begin
                        r_state     <= ST_RUN;
                        r_req_ready <= 1'b1;
                        r_init_done <= 1'b1;
                    end
                end
                ST_RUN: begin
                    r_req_ready <= 1'b1;
                    r_init_done <= 1'b1;
                end
                default: r_state <= ST_INIT;
            endcase
        end
    end

    // During INIT every slice of every bank is written with zero in parallel.
    for (genvar b = 0; b < c_num_banks; b++) begin : g_bank
        for (genvar s = 0; s < c_num_slices; s++) begin : g_slice
            logic w_we;
            assign w_we = w_init | (w_wr & w_bank_sel[b] & req_wmask[s]);

            bank_slice_ram #(
                .WIDTH  (SLICE_WIDTH),
                .ADDR_W (c_local_w)
            ) u_ram (
                .clk     (clk),
                .rst     (rst),
                .i_we    (w_we),
                .i_re    (w_rd & w_bank_sel[b]),
                .i_addr  (w_ram_addr),
                .i_wdata (w_init ? '0 : req_wdata[s*SLICE_WIDTH +: SLICE_WIDTH]),
                .o_rdata (w_bank_rdata[b][s*SLICE_WIDTH +: SLICE_WIDTH])
            );
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = w_bank_rdata[r_rd_bank];
    assign init_done = r_init_done;

`ifdef BANKED_RAM_PERF_EN
    logic [c_perf_w-1:0] r_perf_reads;
    logic [c_perf_w-1:0] r_perf_writes;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_reads  <= '0;
            r_perf_writes <= '0;
        end else begin
            if (w_rd && (r_perf_reads != '1)) begin
                r_perf_reads <= r_perf_reads + 1'b1;
            end
            if (w_wr && (r_perf_writes != '1)) begin
                r_perf_writes <= r_perf_writes + 1'b1;
            end
        end
    end

    assign perf_reads  = r_perf_reads;
    assign perf_writes = r_perf_writes;
`else
    assign perf_reads  = '0;
    assign perf_writes = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_banked_ram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_banked_ram_ctrl
// Description : Scoreboard bench for banked_ram_ctrl (default geometry).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_banked_ram_ctrl;

    localparam int c_aw = 12;
    localparam int c_dw = 16;
    localparam int c_sw = 8;
    localparam int c_bb = 2;
    localparam int c_ns = c_dw / c_sw;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic            req_we = 1'b0;
    logic [c_aw-1:0] req_addr = '0;
    logic [c_dw-1:0] req_wdata = '0;
    logic [c_ns-1:0] req_wmask = '0;
    logic            rsp_valid;
    logic [c_dw-1:0] rsp_rdata;
    logic            init_done;
    logic [15:0]     perf_reads;
    logic [15:0]     perf_writes;

    banked_ram_ctrl #(
        .ADDR_WIDTH  (c_aw),
        .DATA_WIDTH  (c_dw),
        .SLICE_WIDTH (c_sw),
        .BANK_BITS   (c_bb)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_wmask   (req_wmask),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .init_done   (init_done),
        .perf_reads  (perf_reads),
        .perf_writes (perf_writes)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] data;
        logic [31:0] cyc;
    } exp_t;

    exp_t        sb_q[$];
    logic [15:0] model [4096];
    logic [31:0] cyc = '0;
    logic [15:0] last_rdata = '0;
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_rd = 0;
    int          n_wr = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Response side of the scoreboard: exact-cycle and data match.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
                e = sb_q.pop_front();
                chk("rsp_missing", 32'd0, 32'd1);
            end
            if (rsp_valid) begin
                if (sb_q.size() == 0) begin
                    chk("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("rsp_cycle", cyc, e.cyc);
                    chk("rsp_rdata", {16'h0, rsp_rdata}, {16'h0, e.data});
                    last_rdata = e.data;
                end
            end
        end
    end

    task automatic clear_model();
        for (int i = 0; i < 4096; i++) model[i] = '0;
        n_rd = 0;
        n_wr = 0;
    endtask

    task automatic do_write(input logic [11:0] a, input logic [15:0] d, input logic [1:0] m);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = a;
        req_wdata = d;
        req_wmask = m;
        for (int s = 0; s < c_ns; s++) begin
            if (m[s]) model[a][s*c_sw +: c_sw] = d[s*c_sw +: c_sw];
        end
        n_wr++;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_we    = 1'b0;
    endtask

    task automatic do_read(input logic [11:0] a);
        exp_t e;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = a;
        e.data    = model[a];
        e.cyc     = cyc + 1;
        sb_q.push_back(e);
        n_rd++;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_init(input string tag);
        int n;
        n = 0;
        while (n < 3000) begin
            @(negedge clk);
            if (req_ready) break;
            n++;
        end
        chk({tag, "_init_cycles"}, n, 32'd1024);
        chk({tag, "_init_done"}, {31'h0, init_done}, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic check_perf(input string tag);
`ifdef BANKED_RAM_PERF_EN
        chk({tag, "_perf_reads"},  {16'h0, perf_reads},  n_rd);
        chk({tag, "_perf_writes"}, {16'h0, perf_writes}, n_wr);
`else
        chk({tag, "_perf_reads"},  {16'h0, perf_reads},  32'd0);
        chk({tag, "_perf_writes"}, {16'h0, perf_writes}, 32'd0);
`endif
    endtask

    task automatic drain();
        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", sb_q.size(), 32'd0);
    endtask

    initial begin
        logic [11:0] addrs [6];
        addrs = '{12'h005, 12'h405, 12'h805, 12'hC05, 12'h3FF, 12'h400};
        clear_model();

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_req_ready", {31'h0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", {16'h0, rsp_rdata}, 32'd0);
        chk("rst_init_done", {31'h0, init_done}, 32'd0);
        check_perf("rst");
        wait_init("boot");

        do_read(12'h000);
        do_read(12'hFFF);

        do_write(12'hC05, 16'hBEEF, 2'b11);
        do_read(12'hC05);
        do_write(12'hC05, 16'h0012, 2'b01);
        do_read(12'hC05);
        do_write(12'hC05, 16'hFFFF, 2'b00);
        do_read(12'hC05);

        do_write(12'h005, 16'h1111, 2'b11);
        do_write(12'h405, 16'h2222, 2'b11);
        do_write(12'h805, 16'h3333, 2'b11);
        do_write(12'hC05, 16'h4444, 2'b11);
        do_read(12'h005);
        do_read(12'h405);
        do_read(12'h805);
        do_read(12'hC05);

        for (int i = 0; i < 12; i++) begin
            if ($urandom_range(1, 0) == 1)
                do_write(addrs[$urandom_range(5, 0)], 16'($urandom), 2'($urandom));
            else
                do_read(addrs[$urandom_range(5, 0)]);
        end

        drain();
        chk("rdata_hold", {16'h0, rsp_rdata}, {16'h0, last_rdata});
        check_perf("main");

        // Reset lands in the same cycle a read is accepted: response must vanish.
        rst       = 1'b1;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 12'hC05;
        @(posedge clk); #1;
        rst       = 1'b0;
        req_valid = 1'b0;
        clear_model();
        chk("midrst_rsp_valid", {31'h0, rsp_valid}, 32'd0);
        chk("midrst_init_done", {31'h0, init_done}, 32'd0);
        chk("midrst_req_ready", {31'h0, req_ready}, 32'd0);
        wait_init("reinit");
        do_read(12'hC05);

        do_write(12'h123, 16'hA5A5, 2'b11);
        do_write(12'h923, 16'h5A5A, 2'b10);
        do_write(12'h123, 16'h00CC, 2'b01);
        do_read(12'h123);
        do_read(12'h923);
        do_read(12'hC05);
        do_read(12'h000);
        drain();
        check_perf("perf");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        n_errors++;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $fatal(1);
    end

endmodule
`default_nettype wire
